// File: rtl/queue_arb_pkg.sv
// Shared types for the queue arbiter: request ops, queue op-flag encodings,
// response status codes and the arbiter FSM states.
package queue_arb_pkg;

    typedef enum logic [1:0] {
        OP_PUSH   = 2'b00,
        OP_POP    = 2'b01,
        OP_REMOVE = 2'b10,
        OP_MODIFY = 2'b11
    } req_op_e;

    localparam logic [2:0] QF_IDLE   = 3'b000;
    localparam logic [2:0] QF_PUSH   = 3'b100;
    localparam logic [2:0] QF_POP    = 3'b101;
    localparam logic [2:0] QF_REMOVE = 3'b110;
    localparam logic [2:0] QF_MODIFY = 3'b111;

    typedef enum logic [1:0] {
        ST_OK   = 2'b00,
        ST_REG  = 2'b01,
        ST_REM  = 2'b10,
        ST_TIME = 2'b11
    } rsp_status_e;

    typedef enum logic {
        S_ARB    = 1'b0,
        S_POPCHK = 1'b1
    } state_e;

    // Queue flag is the request op with the "active" bit on top.
    function automatic logic [2:0] op_flag(req_op_e op);
        return {1'b1, op};
    endfunction

endpackage

// File: rtl/queue_arbiter_if.sv
// Bundle of requester, queue and response signals around the queue arbiter.
// slave = arbiter side, master = requesters + queue side.
interface queue_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_SIZE = 64,
    parameter int PTR_WIDTH = 6,
    parameter int ID_WIDTH  = 2
);
    logic [NUM_REQ-1:0]                req_valid;
    logic [NUM_REQ-1:0][1:0]           req_op;
    logic [NUM_REQ-1:0][PTR_WIDTH-1:0] req_index;
    logic [NUM_REQ-1:0][DATA_SIZE-1:0] req_data;
    logic [NUM_REQ-1:0]                req_ready;

    logic [2:0]           q_op_flag;
    logic [PTR_WIDTH-1:0] q_op_index;
    logic [DATA_SIZE-1:0] q_op_data;
    logic [DATA_SIZE-1:0] q_pop_data;
    logic                 q_error_reg;
    logic                 q_error_rem;
    logic                 q_error_time;

    logic                 rsp_valid;
    logic [ID_WIDTH-1:0]  rsp_id;
    logic [1:0]           rsp_status;
    logic [DATA_SIZE-1:0] rsp_data;

    modport slave (
        input  req_valid, req_op, req_index, req_data,
        output req_ready,
        output q_op_flag, q_op_index, q_op_data,
        input  q_pop_data, q_error_reg, q_error_rem, q_error_time,
        output rsp_valid, rsp_id, rsp_status, rsp_data
    );

    modport master (
        output req_valid, req_op, req_index, req_data,
        input  req_ready,
        input  q_op_flag, q_op_index, q_op_data,
        output q_pop_data, q_error_reg, q_error_rem, q_error_time,
        input  rsp_valid, rsp_id, rsp_status, rsp_data
    );
endinterface

// File: rtl/queue_arbiter_rr.sv
// Combinational masked round-robin: lowest requester at or above rr_ptr wins,
// otherwise the lowest requester overall.
module rr_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] rr_ptr,
    output logic [NUM_REQ-1:0]  grant,
    output logic [ID_WIDTH-1:0] grant_id,
    output logic                any
);
    logic [NUM_REQ-1:0] mask;
    logic [NUM_REQ-1:0] masked;
    logic               found;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_mask
        assign mask[i] = (ID_WIDTH'(i) >= rr_ptr);
    end

    assign masked = req & mask;
    assign any    = |req;

    always_comb begin
        grant_id = '0;
        found    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && masked[i]) begin
                grant_id = ID_WIDTH'(i);
                found    = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i]) begin
                grant_id = ID_WIDTH'(i);
                found    = 1'b1;
            end
        end
        grant = found ? (NUM_REQ'(1) << grant_id) : '0;
    end

endmodule

// File: rtl/queue_arbiter.sv
// Round-robin front end sharing one index-addressed queue between NUM_REQ
// requesters; pops rejected with error_time are re-issued up to MAX_RETRY times.
module queue_arbiter
    import queue_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_SIZE = 64,
    parameter int FIFO_SIZE = 64,
    parameter int PTR_WIDTH = $clog2(FIFO_SIZE),
    parameter int ID_WIDTH  = $clog2(NUM_REQ),
    parameter int MAX_RETRY = 3
) (
    input logic           clk,
    input logic           reset,
    queue_arbiter_if.slave bus
);
    localparam int RETRY_W = $clog2(MAX_RETRY + 2);
    localparam logic [RETRY_W-1:0] MAX_RETRY_C = RETRY_W'(MAX_RETRY);

    state_e               state_q, state_d;
    logic [ID_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;
    logic [ID_WIDTH-1:0]  id_q, id_d;
    req_op_e              op_q, op_d;
    logic [DATA_SIZE-1:0] pop_data_q, pop_data_d;
    logic                 pend_q, pend_d;
    logic [RETRY_W-1:0]   retry_cnt_q, retry_cnt_d;

    logic [NUM_REQ-1:0]   grant;
    logic [ID_WIDTH-1:0]  grant_id;
    logic                 any_req;
    req_op_e              gop;

    rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_rr (
        .req      (bus.req_valid),
        .rr_ptr   (rr_ptr_q),
        .grant    (grant),
        .grant_id (grant_id),
        .any      (any_req)
    );

    assign gop = req_op_e'(bus.req_op[grant_id]);

    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        id_d           = id_q;
        op_d           = op_q;
        pop_data_d     = pop_data_q;
        pend_d         = 1'b0;
        retry_cnt_d    = retry_cnt_q;
        bus.req_ready  = '0;
        bus.q_op_flag  = QF_IDLE;
        bus.q_op_index = '0;
        bus.q_op_data  = '0;
        bus.rsp_valid  = 1'b0;
        bus.rsp_id     = '0;
        bus.rsp_status = ST_OK;
        bus.rsp_data   = '0;

        // Outputs stay quiet during reset so an in-flight op never responds.
        if (!reset) begin
            if (state_q == S_ARB) begin
                // Response for the non-pop issued last cycle overlaps the next issue.
                if (pend_q) begin
                    bus.rsp_valid = 1'b1;
                    bus.rsp_id    = id_q;
                    if (op_q == OP_PUSH)
                        bus.rsp_status = bus.q_error_reg ? ST_REG : ST_OK;
                    else
                        bus.rsp_status = bus.q_error_rem ? ST_REM : ST_OK;
                end
                if (any_req) begin
                    bus.req_ready  = grant;
                    bus.q_op_flag  = op_flag(gop);
                    bus.q_op_index = bus.req_index[grant_id];
                    bus.q_op_data  = bus.req_data[grant_id];
                    rr_ptr_d       = grant_id + ID_WIDTH'(1);
                    id_d           = grant_id;
                    op_d           = gop;
                    pop_data_d     = bus.q_pop_data;
                    if (gop == OP_POP) state_d = S_POPCHK;
                    else               pend_d  = 1'b1;
                end
            end else begin
                if (bus.q_error_time && (retry_cnt_q < MAX_RETRY_C)) begin
                    bus.q_op_flag = QF_POP;
                    pop_data_d    = bus.q_pop_data;
                    retry_cnt_d   = retry_cnt_q + RETRY_W'(1);
                end else begin
                    bus.rsp_valid = 1'b1;
                    bus.rsp_id    = id_q;
                    retry_cnt_d   = '0;
                    state_d       = S_ARB;
                    if (bus.q_error_time) begin
                        bus.rsp_status = ST_TIME;
                    end else if (bus.q_error_reg) begin
                        bus.rsp_status = ST_REG;
                    end else begin
                        bus.rsp_status = ST_OK;
                        bus.rsp_data   = pop_data_q;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_ARB;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            op_q        <= OP_PUSH;
            pop_data_q  <= '0;
            pend_q      <= 1'b0;
            retry_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            op_q        <= op_d;
            pop_data_q  <= pop_data_d;
            pend_q      <= pend_d;
            retry_cnt_q <= retry_cnt_d;
        end
    end

endmodule

// File: tb/tb_queue_arbiter.sv
// Directed bench for queue_arbiter: the bench plays all requesters and the
// queue, hand-driving the queue error flags and pop data cycle by cycle.
module tb_queue_arbiter;

    logic clk;
    logic reset;
    int   total;
    int   passed;

    queue_arbiter_if #(.NUM_REQ(4), .DATA_SIZE(64), .PTR_WIDTH(6), .ID_WIDTH(2)) bus ();

    queue_arbiter #(
        .NUM_REQ   (4),
        .DATA_SIZE (64),
        .FIFO_SIZE (64),
        .MAX_RETRY (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input int i, input logic [1:0] op, input logic [5:0] idx,
                             input logic [63:0] d);
        bus.req_valid[i] = 1'b1;
        bus.req_op[i]    = op;
        bus.req_index[i] = idx;
        bus.req_data[i]  = d;
    endtask

    task automatic idle_all();
        bus.req_valid = '0;
    endtask

    initial begin
        total  = 0;
        passed = 0;
        reset  = 1'b1;
        bus.req_valid    = '0;
        bus.req_op       = '0;
        bus.req_index    = '0;
        bus.req_data     = '0;
        bus.q_pop_data   = '0;
        bus.q_error_reg  = 1'b0;
        bus.q_error_rem  = 1'b0;
        bus.q_error_time = 1'b0;
        drive_req(0, 2'b00, 6'd0, 64'h1);
        step();
        step();
        #1;
        chk("rst_ready",  64'(bus.req_ready),  64'h0);
        chk("rst_flag",   64'(bus.q_op_flag),  64'h0);
        chk("rst_index",  64'(bus.q_op_index), 64'h0);
        chk("rst_data",   bus.q_op_data,       64'h0);
        chk("rst_rvalid", 64'(bus.rsp_valid),  64'h0);
        chk("rst_rid",    64'(bus.rsp_id),     64'h0);
        chk("rst_rstat",  64'(bus.rsp_status), 64'h0);
        chk("rst_rdata",  bus.rsp_data,        64'h0);
        reset = 1'b0;
        idle_all();
        step();

        // Single push from req0
        drive_req(0, 2'b00, 6'd0, 64'hA5);
        #1;
        chk("push_ready", 64'(bus.req_ready), 64'h1);
        chk("push_flag",  64'(bus.q_op_flag), 64'h4);
        chk("push_data",  bus.q_op_data,      64'hA5);
        step();
        idle_all();
        #1;
        chk("push_rvalid", 64'(bus.rsp_valid),  64'h1);
        chk("push_rid",    64'(bus.rsp_id),     64'h0);
        chk("push_rstat",  64'(bus.rsp_status), 64'h0);
        chk("push_rdata",  bus.rsp_data,        64'h0);
        chk("push_idle",   64'(bus.q_op_flag),  64'h0);

        // req3 push moves the pointer back to 0
        drive_req(3, 2'b00, 6'd0, 64'h33);
        #1;
        chk("p3_ready", 64'(bus.req_ready), 64'h8);
        step();
        idle_all();

        // All four push continuously: grants 0,1,2,3,0,1
        for (int i = 0; i < 4; i++) drive_req(i, 2'b00, 6'd0, 64'h10 + 64'(i));
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("rr_ready",  64'(bus.req_ready), 64'(4'b0001 << (k % 4)));
            chk("rr_data",   bus.q_op_data,      64'h10 + 64'(k % 4));
            chk("rr_rvalid", 64'(bus.rsp_valid), 64'h1);
            chk("rr_rid",    64'(bus.rsp_id),    (k == 0) ? 64'h3 : 64'((k - 1) % 4));
            step();
        end
        idle_all();
        #1;
        chk("rr_last_rvalid", 64'(bus.rsp_valid), 64'h1);
        chk("rr_last_rid",    64'(bus.rsp_id),    64'h1);
        chk("rr_last_ready",  64'(bus.req_ready), 64'h0);
        step();
        #1;
        chk("rr_quiet", 64'(bus.rsp_valid), 64'h0);

        // req2 pop: error_time after issues 1 and 2, data on issue 3
        drive_req(2, 2'b01, 6'd0, 64'h0);
        #1;
        chk("pop_ready", 64'(bus.req_ready), 64'h4);
        chk("pop_flag1", 64'(bus.q_op_flag), 64'h5);
        step();
        idle_all();
        bus.q_error_time = 1'b1;
        bus.q_pop_data   = 64'h0;
        #1;
        chk("pop_flag2",   64'(bus.q_op_flag), 64'h5);
        chk("pop_norsp2",  64'(bus.rsp_valid), 64'h0);
        step();
        bus.q_pop_data = 64'h1234;
        #1;
        chk("pop_flag3",   64'(bus.q_op_flag), 64'h5);
        chk("pop_norsp3",  64'(bus.rsp_valid), 64'h0);
        step();
        bus.q_error_time = 1'b0;
        bus.q_pop_data   = 64'hDEAD;
        #1;
        chk("pop_rvalid", 64'(bus.rsp_valid),  64'h1);
        chk("pop_rid",    64'(bus.rsp_id),     64'h2);
        chk("pop_rstat",  64'(bus.rsp_status), 64'h0);
        chk("pop_rdata",  bus.rsp_data,        64'h1234);
        chk("pop_idle",   64'(bus.q_op_flag),  64'h0);
        step();

        // Pop timeout: error_time after all four issues; req0 waits meanwhile
        bus.q_pop_data = 64'hBAD;
        drive_req(2, 2'b01, 6'd0, 64'h0);
        #1;
        chk("to_ready", 64'(bus.req_ready), 64'h4);
        chk("to_flag",  64'(bus.q_op_flag), 64'h5);
        step();
        idle_all();
        drive_req(0, 2'b00, 6'd0, 64'h77);
        bus.q_error_time = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("to_retry_flag",  64'(bus.q_op_flag), 64'h5);
            chk("to_retry_ready", 64'(bus.req_ready), 64'h0);
            chk("to_retry_norsp", 64'(bus.rsp_valid), 64'h0);
            step();
        end
        #1;
        chk("to_flag_end", 64'(bus.q_op_flag),  64'h0);
        chk("to_rvalid",   64'(bus.rsp_valid),  64'h1);
        chk("to_rid",      64'(bus.rsp_id),     64'h2);
        chk("to_rstat",    64'(bus.rsp_status), 64'h3);
        chk("to_rdata",    bus.rsp_data,        64'h0);
        chk("to_noready",  64'(bus.req_ready),  64'h0);
        step();
        bus.q_error_time = 1'b0;
        #1;
        chk("to_next_ready", 64'(bus.req_ready), 64'h1);
        chk("to_next_flag",  64'(bus.q_op_flag), 64'h4);
        step();
        idle_all();
        #1;
        chk("to_next_rid",   64'(bus.rsp_id),     64'h0);
        chk("to_next_rstat", 64'(bus.rsp_status), 64'h0);
        step();

        // req1 remove at index 5 with invalid-index error
        drive_req(1, 2'b10, 6'd5, 64'h0);
        #1;
        chk("rem_ready", 64'(bus.req_ready),  64'h2);
        chk("rem_flag",  64'(bus.q_op_flag),  64'h6);
        chk("rem_index", 64'(bus.q_op_index), 64'h5);
        step();
        idle_all();
        bus.q_error_rem = 1'b1;
        #1;
        chk("rem_rvalid", 64'(bus.rsp_valid),  64'h1);
        chk("rem_rid",    64'(bus.rsp_id),     64'h1);
        chk("rem_rstat",  64'(bus.rsp_status), 64'h2);
        chk("rem_rdata",  bus.rsp_data,        64'h0);
        step();
        bus.q_error_rem = 1'b0;

        // req3 modify: error_reg must not affect a modify
        drive_req(3, 2'b11, 6'd9, 64'hBEEF);
        #1;
        chk("mod_flag",  64'(bus.q_op_flag),  64'h7);
        chk("mod_index", 64'(bus.q_op_index), 64'h9);
        chk("mod_data",  bus.q_op_data,       64'hBEEF);
        step();
        idle_all();
        bus.q_error_reg = 1'b1;
        #1;
        chk("mod_rid",   64'(bus.rsp_id),     64'h3);
        chk("mod_rstat", 64'(bus.rsp_status), 64'h0);
        step();
        bus.q_error_reg = 1'b0;

        // Push overflow
        drive_req(0, 2'b00, 6'd0, 64'h1);
        step();
        idle_all();
        bus.q_error_reg = 1'b1;
        #1;
        chk("ovf_rid",   64'(bus.rsp_id),     64'h0);
        chk("ovf_rstat", 64'(bus.rsp_status), 64'h1);
        step();
        bus.q_error_reg = 1'b0;

        // Pop on empty queue
        bus.q_pop_data = 64'h55;
        drive_req(2, 2'b01, 6'd0, 64'h0);
        #1;
        chk("emp_ready", 64'(bus.req_ready), 64'h4);
        step();
        idle_all();
        bus.q_error_reg = 1'b1;
        #1;
        chk("emp_rvalid", 64'(bus.rsp_valid),  64'h1);
        chk("emp_rid",    64'(bus.rsp_id),     64'h2);
        chk("emp_rstat",  64'(bus.rsp_status), 64'h1);
        chk("emp_rdata",  bus.rsp_data,        64'h0);
        step();
        bus.q_error_reg = 1'b0;

        // Reset during the first pop-check cycle
        drive_req(2, 2'b01, 6'd0, 64'h0);
        #1;
        chk("rp_flag", 64'(bus.q_op_flag), 64'h5);
        step();
        idle_all();
        reset = 1'b1;
        bus.q_error_time = 1'b1;
        #1;
        chk("rp_in_flag",   64'(bus.q_op_flag), 64'h0);
        chk("rp_in_rvalid", 64'(bus.rsp_valid), 64'h0);
        step();
        reset = 1'b0;
        #1;
        chk("rp_post_flag",   64'(bus.q_op_flag), 64'h0);
        chk("rp_post_rvalid", 64'(bus.rsp_valid), 64'h0);
        chk("rp_post_ready",  64'(bus.req_ready), 64'h0);
        step();
        bus.q_error_time = 1'b0;
        drive_req(1, 2'b00, 6'd0, 64'h11);
        drive_req(3, 2'b00, 6'd0, 64'h13);
        #1;
        chk("rp_grant", 64'(bus.req_ready), 64'h2);
        step();
        idle_all();
        #1;
        chk("rp_rvalid", 64'(bus.rsp_valid), 64'h1);
        chk("rp_rid",    64'(bus.rsp_id),    64'h1);
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
